uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter (`tx_start`/`data_in` side of `uart_top`) between N byte-producing requesters. It accepts one byte at a time from the winning requester, launches it on the UART with a one-cycle `tx_start` pulse, and tracks the frame through the transmitter's busy flag. A per-byte `last` flag lets a requester lock the channel so that a multi-byte packet goes out unbroken. It sits between client logic (command responder, debug printer, etc.) and `uart_top`.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 16: max cycles to wait for `tx_busy` to rise after `tx_start` (≥2).
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in N: `req[i]` high = requester i presents a byte; held until acked.
- `req_data` in 8*N: byte of requester i at `[8*i+7:8*i]`; stable while `req[i]`.
- `req_last` in N: qualifies the byte; 1 = last byte of packet (releases lock), 0 = more follow.
- `ack` out N: one-cycle pulse, byte of requester i accepted; requester may change data/drop `req` from the next edge.
- `tx_start` out 1: one-cycle launch pulse to UART.
- `tx_data` out 8: byte to UART; held stable from `tx_start` until return to IDLE.
- `tx_busy` in 1: UART transmitter busy (frame in flight).
- `owner` out clog2(N): index of last granted requester.
- `locked` out 1: channel reserved for `owner`.
- `err` out 1: one-cycle pulse on busy-rise timeout.

## Operation
- Reset values: `ack`=0, `tx_start`=0, `tx_data`=0, `owner`=0, `locked`=0, `err`=0, state IDLE, RR pointer 0, timeout counter 0.
- States: IDLE, WAIT_ACCEPT, WAIT_DONE.
- IDLE: candidate set = `req` if `locked`=0, else only `req[owner]`. Winner = first set bit searching from pointer upward, wrapping at N-1→0. If a winner w exists, on the edge: `tx_data`←byte w, `tx_start`←1, `ack[w]`←1, `owner`←w, `locked`←~`req_last[w]`, pointer←(w+1) mod N, counter←0, → WAIT_ACCEPT. No candidate: stay, outputs unchanged.
- Locked and owner not requesting: stay IDLE indefinitely; other requesters starve by design. Lock ends only on a `req_last`=1 byte, timeout, or reset.
- WAIT_ACCEPT: `tx_busy`=1 → WAIT_DONE. Else counter+1; when counter reaches `TIMEOUT`-1 with `tx_busy` still 0: `err`←1 for one cycle, `locked`←0, → IDLE (byte dropped; already acked).
- WAIT_DONE: `tx_busy`=0 → IDLE.
- `req` changes outside IDLE are ignored; no byte is accepted outside IDLE.
- Reset mid-frame: all outputs return to reset values at once; UART frame in flight is not aborted by this block.

## Timing
- Request high at edge k (state IDLE) → `tx_start`=1 and `ack[w]`=1 during cycle k+1, both low in k+2.
- `tx_busy` sampled from cycle k+1 onward; busy rising in the same cycle as `tx_start` is accepted.
- Return to IDLE one cycle after `tx_busy` is sampled low in WAIT_DONE; next `tx_start` no earlier than one cycle after that (min two cycles between busy low and next launch).
- Timeout: `err` pulses in cycle k+1+`TIMEOUT`; state IDLE the same cycle.
- Exactly one `ack` bit and one `tx_start` per accepted byte; `ack` and `tx_start` always coincide.

## Test plan
- Single requester: `req[0]`=1, data 8'hA5, last=1 → one `tx_start` with `tx_data`=A5, `ack[0]` same cycle, `uart_top` `rx_data`=A5 with `rx_done`.
- Round-robin: `req[3:0]`=4'b1111 continuously, last=1, data=8'h10+i → launch order 0,1,2,3,0; `owner` follows; no requester granted twice before others.
- Lock: requester 1 sends 8'h5B (last=0), 8'h5C (last=1) while `req[2]` held → launches 5B, 5C, then requester 2's byte; `locked`=1 between 5B and 5C.
- Timeout: tie `tx_busy`=0, `req[0]`=1 with `TIMEOUT`=16 → `err` pulse 16 cycles after `tx_start`, `locked`=0, state IDLE, next request relaunched.
- Reset mid-frame: assert `reset` during WAIT_DONE with `locked`=1 → `tx_start`,`ack`,`tx_data`,`owner`,`locked` zero immediately; after release, next grant starts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte requesters,
// with per-packet channel locking and a busy-rise timeout.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [8*N-1:0]         req_data,
  input  logic [N-1:0]           req_last,
  output logic [N-1:0]           ack,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   locked,
  output logic                   err
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_ACCEPT, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N-1:0]    ack_nxt;
  logic            tx_start_nxt;
  logic [7:0]      tx_data_nxt;
  logic [OW-1:0]   owner_nxt;
  logic            locked_nxt;
  logic            err_nxt;

  logic [N-1:0]    cand;
  logic            found;
  logic [OW-1:0]   win;
  logic [7:0]      win_data;
  logic            win_last;
  int unsigned     idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      ack      <= ack_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      owner    <= owner_nxt;
      locked   <= locked_nxt;
      err      <= err_nxt;
    end
  end

  // While locked only the current owner may compete.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cand[i] = locked ? (req[i] && (owner == OW'(i))) : req[i];
    end
  end

  // Rotating-priority search starting at ptr, wrapping at N-1.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_last = 1'b0;
    idx      = 0;
    for (int off = 0; off < int'(N); off++) begin
      idx = 32'(ptr) + 32'(off);
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx]) begin
        found    = 1'b1;
        win      = OW'(idx);
        win_data = req_data[8*idx +: 8];
        win_last = req_last[idx];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    owner_nxt    = owner;
    locked_nxt   = locked;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_nxt  = win_data;
          tx_start_nxt = 1'b1;
          ack_nxt      = N'(1) << win;
          owner_nxt    = win;
          locked_nxt   = ~win_last;
          ptr_nxt      = (win == OW'(N-1)) ? '0 : win + OW'(1);
          cnt_nxt      = '0;
          state_nxt    = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          // Byte was already acked, so it is simply dropped.
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, UART busy model,
// and a monitor that checks every launch against hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned OW      = $clog2(N);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [8*N-1:0]    req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [OW-1:0]     owner;
  logic              locked;
  logic              err;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_last(req_last), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .owner(owner), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned id;
    logic        lck;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  rq[N][$];
  int          total = 0;
  int          bad = 0;
  logic        err_ok = 1'b0;
  logic        busy_en = 1'b1;
  int unsigned frame_len = 6;
  int unsigned bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // UART transmitter stand-in: busy rises the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start && busy_en) bcnt <= frame_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Requesters: present queue heads, pop on ack.
  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      if (rq[i].size() != 0) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]       = rq[i][0][8];
      end else begin
        req[i]            = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start || ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_launch", 32'(ack), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("launch_start", 32'(tx_start), 32'(1));
          chk("launch_data", 32'(tx_data), 32'(e.data));
          chk("launch_ack", 32'(ack), 32'(1) << e.id);
          chk("launch_owner", 32'(owner), e.id);
          chk("launch_locked", 32'(locked), 32'(e.lck));
        end
      end
      if (err) chk("err_allowed", 32'(1), 32'(err_ok));
    end
  end

  task automatic push_exp(input logic [7:0] d, input int unsigned id, input logic l);
    exp_t e;
    e.data = d; e.id = id; e.lck = l;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'(0));
    while (tx_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic timeout_run(input string name);
    int n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_start_seen"}, 32'(tx_start), 32'(1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 40);
    chk({name, "_err_delay"}, 32'(n), 32'(TIMEOUT));
    chk({name, "_unlock"}, 32'(locked), 32'(0));
    @(negedge clk);
    chk({name, "_err_pulse"}, 32'(err), 32'(0));
  endtask

  initial begin
    do_reset();

    // Single requester.
    push_exp(8'hA5, 0, 1'b0);
    rq[0].push_back({1'b1, 8'hA5});
    wait_drain("single_drain", 100);

    // Round robin from pointer 0, two bytes per requester.
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(8'(8'h10 + i), i, 1'b0);
    for (int i = 0; i < 4; i++) push_exp(8'(8'h20 + i), i, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rq[i].push_back({1'b1, 8'(8'h10 + i)});
      rq[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    wait_drain("rr_drain", 400);

    // Lock: requester 2 starves until requester 1 finishes its packet.
    do_reset();
    push_exp(8'h5B, 1, 1'b1);
    push_exp(8'h5C, 1, 1'b0);
    push_exp(8'h77, 2, 1'b0);
    rq[1].push_back({1'b0, 8'h5B});
    rq[2].push_back({1'b1, 8'h77});
    repeat (50) @(negedge clk);
    chk("lock_starve_pending", 32'(exp_q.size()), 32'(2));
    chk("lock_held", 32'(locked), 32'(1));
    rq[1].push_back({1'b1, 8'h5C});
    wait_drain("lock_drain", 200);

    // Busy never rises: timeout, unlock, then relaunch.
    do_reset();
    busy_en = 1'b0;
    err_ok  = 1'b1;
    push_exp(8'h3C, 0, 1'b1);
    rq[0].push_back({1'b0, 8'h3C});
    timeout_run("to1");
    push_exp(8'h3D, 0, 1'b0);
    rq[0].push_back({1'b1, 8'h3D});
    timeout_run("to2");
    chk("to_drain", 32'(exp_q.size()), 32'(0));
    busy_en = 1'b1;
    err_ok  = 1'b0;

    // Reset during a long locked frame, then grant restarts at requester 0.
    do_reset();
    frame_len = 30;
    push_exp(8'h5B, 1, 1'b1);
    rq[1].push_back({1'b0, 8'h5B});
    begin
      int n = 0;
      while (!(tx_busy && locked) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(tx_busy), 32'(1));
    do_reset();
    frame_len = 6;
    begin
      int n = 0;
      while (tx_busy && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    push_exp(8'hA0, 0, 1'b0);
    push_exp(8'hA1, 1, 1'b0);
    push_exp(8'hA3, 3, 1'b0);
    rq[0].push_back({1'b1, 8'hA0});
    rq[1].push_back({1'b1, 8'hA1});
    rq[3].push_back({1'b1, 8'hA3});
    wait_drain("post_reset_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
